// File: rtl/npc_pkg.sv
// npc_pkg: shared definitions for the npc control sequencer.
//   state_t       - sequencer state encoding
//   halt_reason_t - encoding driven on npc_seq.halt_reason
//   INST_EBREAK   - instruction word that halts the core
//   INST_NOP      - value of the latched instruction after reset
package npc_pkg;

    typedef enum logic [2:0] {
        FETCH    = 3'd0,
        WAIT_RSP = 3'd1,
        DECODE   = 3'd2,
        EXEC     = 3'd3,
        HALT     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        HR_NONE    = 2'd0,
        HR_EBREAK  = 2'd1,
        HR_ILLEGAL = 2'd2,
        HR_TIMEOUT = 2'd3
    } halt_reason_t;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_NOP    = 32'h0000_0013;

endpackage

// File: rtl/npc_perf_cnt.sv
// npc_perf_cnt: cycle and retired-instruction counters for the simulation harness.
// Ports:
//   clk         in   core clock
//   rst         in   synchronous active-low reset
//   count_en    in   advance cycle_cnt this cycle
//   retire      in   advance instret_cnt this cycle
//   cycle_cnt   out  XLEN-bit cycle counter, wraps
//   instret_cnt out  XLEN-bit retired-instruction counter, wraps
module npc_perf_cnt #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            count_en,
    input  logic            retire,
    output logic [XLEN-1:0] cycle_cnt,
    output logic [XLEN-1:0] instret_cnt
);

    localparam logic [XLEN-1:0] ONE = XLEN'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (count_en) begin
                cycle_cnt <= cycle_cnt + ONE;
            end
            if (retire) begin
                instret_cnt <= instret_cnt + ONE;
            end
        end
    end

endmodule

// File: rtl/npc_seq.sv
// npc_seq: multi-cycle control sequencer for the npc RV64 core.
// Each instruction walks FETCH -> WAIT_RSP -> DECODE -> EXEC and commits once in EXEC.
// ebreak, an illegal instruction or a fetch timeout park the sequencer in HALT
// until reset.
// Ports:
//   clk, rst                      core clock, synchronous active-low reset
//   pc_val                        current PC
//   imem_req_valid/ready/addr     fetch request handshake
//   imem_rsp_valid/data           fetch response
//   inst                          latched instruction for idu/exu
//   illegal                       idu decode failure
//   ex_wen                        exu GPR write request
//   gpr_wen, pc_wen               commit strobes, only in EXEC
//   halted, halt_reason           sticky halt status
//   cycle_cnt, instret_cnt        harness counters
module npc_seq
    import npc_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_val,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [31:0]     inst,
    input  logic            illegal,
    input  logic            ex_wen,
    output logic            gpr_wen,
    output logic            pc_wen,
    output logic            halted,
    output logic [1:0]      halt_reason,
    output logic [XLEN-1:0] cycle_cnt,
    output logic [XLEN-1:0] instret_cnt
);

    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               TO_EN    = (TIMEOUT != 0);

    state_t            state, state_nxt;
    halt_reason_t      reason_q, reason_nxt;
    logic [31:0]       inst_q, inst_nxt;
    logic              halted_q, halted_nxt;
    logic [CNT_W-1:0]  to_cnt, to_cnt_nxt, to_cnt_inc;

    assign to_cnt_inc = to_cnt + CNT_ONE;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= FETCH;
            inst_q   <= INST_NOP;
            halted_q <= 1'b0;
            reason_q <= HR_NONE;
            to_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            inst_q   <= inst_nxt;
            halted_q <= halted_nxt;
            reason_q <= reason_nxt;
            to_cnt   <= to_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        inst_nxt       = inst_q;
        halted_nxt     = halted_q;
        reason_nxt     = reason_q;
        to_cnt_nxt     = to_cnt;
        imem_req_valid = 1'b0;
        gpr_wen        = 1'b0;
        pc_wen         = 1'b0;

        case (state)
            FETCH: begin
                // rst is active-low: no request is offered while reset is held.
                imem_req_valid = rst;
                if (imem_req_valid && imem_req_ready) begin
                    state_nxt = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (imem_rsp_valid) begin
                    // A response arriving on the timeout cycle still wins.
                    inst_nxt   = imem_rsp_data;
                    to_cnt_nxt = '0;
                    state_nxt  = DECODE;
                end else begin
                    to_cnt_nxt = to_cnt_inc;
                    if (TO_EN && (to_cnt_inc == TO_LIMIT)) begin
                        state_nxt  = HALT;
                        halted_nxt = 1'b1;
                        reason_nxt = HR_TIMEOUT;
                    end
                end
            end
            DECODE: begin
                if (inst_q == INST_EBREAK) begin
                    state_nxt  = HALT;
                    halted_nxt = 1'b1;
                    reason_nxt = HR_EBREAK;
                end else if (illegal) begin
                    state_nxt  = HALT;
                    halted_nxt = 1'b1;
                    reason_nxt = HR_ILLEGAL;
                end else begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                gpr_wen   = ex_wen;
                pc_wen    = 1'b1;
                state_nxt = FETCH;
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    assign imem_req_addr = pc_val;
    assign inst          = inst_q;
    assign halted        = halted_q;
    assign halt_reason   = reason_q;

    // The cycle of the transition into HALT is still counted.
    npc_perf_cnt #(
        .XLEN (XLEN)
    ) u_perf_cnt (
        .clk         (clk),
        .rst         (rst),
        .count_en    (state != HALT),
        .retire      (state == EXEC),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

endmodule

// File: tb/tb_npc_seq.sv
`timescale 1ns/1ps
module tb_npc_seq;

    localparam logic [63:0] PC0     = 64'h0000_0000_8000_0000;
    localparam logic [31:0] I_ADDI1 = 32'h0010_0093;
    localparam logic [31:0] I_ADDI2 = 32'h0020_0113;
    localparam logic [31:0] I_ADDI3 = 32'h0030_0193;
    localparam logic [31:0] I_EBRK  = 32'h0010_0073;
    localparam logic [31:0] I_NOP   = 32'h0000_0013;
    localparam logic [31:0] I_ILL   = 32'hffff_ffff;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] pc_val = PC0;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        ex_wen = 1'b1;
    logic        force_ill = 1'b0;
    logic        illegal;

    logic        a_req_valid, a_gpr_wen, a_pc_wen, a_halted;
    logic [63:0] a_req_addr, a_cycle_cnt, a_instret_cnt;
    logic [31:0] a_inst;
    logic [1:0]  a_halt_reason;
    logic        f_req_valid, f_gpr_wen, f_pc_wen, f_halted;
    logic [63:0] f_req_addr, f_cycle_cnt, f_instret_cnt;
    logic [31:0] f_inst;
    logic [1:0]  f_halt_reason;
    logic        z_req_valid, z_gpr_wen, z_pc_wen, z_halted;
    logic [63:0] z_req_addr, z_cycle_cnt, z_instret_cnt;
    logic [31:0] z_inst;
    logic [1:0]  z_halt_reason;

    always #5 clk = ~clk;

    // idu model: only the illegal pattern (or a forced flag) is undecodable
    assign illegal = (a_inst == I_ILL) || force_ill;

    npc_seq dut (
        .clk(clk), .rst(rst), .pc_val(pc_val),
        .imem_req_valid(a_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(a_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .inst(a_inst),
        .illegal(illegal), .ex_wen(ex_wen), .gpr_wen(a_gpr_wen), .pc_wen(a_pc_wen),
        .halted(a_halted), .halt_reason(a_halt_reason),
        .cycle_cnt(a_cycle_cnt), .instret_cnt(a_instret_cnt)
    );

    npc_seq #(.TIMEOUT(4)) dut_t4 (
        .clk(clk), .rst(rst), .pc_val(pc_val),
        .imem_req_valid(f_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(f_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .inst(f_inst),
        .illegal(illegal), .ex_wen(ex_wen), .gpr_wen(f_gpr_wen), .pc_wen(f_pc_wen),
        .halted(f_halted), .halt_reason(f_halt_reason),
        .cycle_cnt(f_cycle_cnt), .instret_cnt(f_instret_cnt)
    );

    npc_seq #(.TIMEOUT(0)) dut_t0 (
        .clk(clk), .rst(rst), .pc_val(pc_val),
        .imem_req_valid(z_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(z_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .inst(z_inst),
        .illegal(illegal), .ex_wen(ex_wen), .gpr_wen(z_gpr_wen), .pc_wen(z_pc_wen),
        .halted(z_halted), .halt_reason(z_halt_reason),
        .cycle_cnt(z_cycle_cnt), .instret_cnt(z_instret_cnt)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic        is_halt;
        logic [63:0] pc;
        logic        wen;
        logic [1:0]  reason;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rom [0:7];
    int          mem_ready_low = 0;
    int          mem_delay = 1;   // cycles from accept to response; 0 = never respond

    // Memory + pc register model. Acts on negedges; requests come from dut.
    initial begin : mem_model
        int          wait_left;
        int          rdy_cnt;
        int          idx;
        bit          pending;
        bit          pc_inc;
        logic [63:0] req_pc;
        logic [31:0] d;
        exp_t        e;
        wait_left = 0; rdy_cnt = 0; pending = 0; pc_inc = 0; req_pc = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pc_val = PC0;
                pc_inc = 0;
            end else if (pc_inc) begin
                pc_val = pc_val + 64'd4;
            end
            pc_inc = rst && a_pc_wen;

            imem_rsp_valid = 1'b0;
            if (pending) begin
                if (wait_left <= 1) begin
                    idx = int'((req_pc - PC0) >> 2) & 7;
                    d = rom[idx];
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = d;
                    pending = 0;
                    e.pc  = req_pc;
                    e.wen = ex_wen;
                    if (d == I_EBRK) begin
                        e.is_halt = 1'b1; e.reason = 2'd1;
                    end else if (d == I_ILL || force_ill) begin
                        e.is_halt = 1'b1; e.reason = 2'd2;
                    end else begin
                        e.is_halt = 1'b0; e.reason = 2'd0;
                    end
                    exp_q.push_back(e);
                end else begin
                    wait_left--;
                end
            end

            if (rst && a_req_valid) begin
                if (rdy_cnt < mem_ready_low) begin
                    imem_req_ready = 1'b0;
                    rdy_cnt++;
                end else begin
                    imem_req_ready = 1'b1;
                    rdy_cnt = 0;
                    if (mem_delay > 0) begin
                        pending   = 1;
                        wait_left = mem_delay;
                        req_pc    = pc_val;
                    end
                end
            end else begin
                imem_req_ready = (mem_ready_low == 0);
                rdy_cnt = 0;
            end
        end
    end

    // Scoreboard monitor for dut: commits on pc_wen, halts on halted rising.
    initial begin : sb_mon
        logic halted_prev;
        exp_t e;
        halted_prev = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (!rst) begin
                halted_prev = 1'b0;
            end else begin
                if (a_pc_wen) begin
                    chk("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("sb_kind", 64'(e.is_halt), 64'd0);
                        chk("sb_pc", pc_val, e.pc);
                        chk("sb_gpr_wen", 64'(a_gpr_wen), 64'(e.wen));
                    end
                end
                if (a_halted && !halted_prev && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sb_halt_kind", 64'(e.is_halt), 64'd1);
                    chk("sb_halt_reason", 64'(a_halt_reason), 64'(e.reason));
                end
                halted_prev = a_halted;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Hold reset 8 cycles, return just after release: the caller is then in cycle 0.
    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        exp_q.delete();
        #1 rst = 1'b1;
    endtask

    initial begin : main
        logic [63:0] pw_mask;
        int          gw, pcw, hs, pulses;

        // ---------------- reset values ----------------
        rom = '{I_ADDI1, I_ADDI2, I_ADDI3, I_EBRK, I_NOP, I_NOP, I_NOP, I_NOP};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid", 64'(a_req_valid), 64'd0);
        chk("rst_inst", 64'(a_inst), 64'(I_NOP));
        chk("rst_gpr_wen", 64'(a_gpr_wen), 64'd0);
        chk("rst_pc_wen", 64'(a_pc_wen), 64'd0);
        chk("rst_halted", 64'(a_halted), 64'd0);
        chk("rst_reason", 64'(a_halt_reason), 64'd0);
        chk("rst_cycle", a_cycle_cnt, 64'd0);
        chk("rst_instret", a_instret_cnt, 64'd0);

        // ---------------- program: 3 x addi + ebreak ----------------
        mem_ready_low = 0; mem_delay = 1;
        do_reset();
        pw_mask = '0;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk); #1;
            if (a_pc_wen) pw_mask[k] = 1'b1;
            if (k == 3) chk("t1_gpr_wen_c3", 64'(a_gpr_wen), 64'd1);
            if (k == 4) chk("t1_instret_c4", a_instret_cnt, 64'd1);
            if (k == 14) chk("t1_not_halted_c14", 64'(a_halted), 64'd0);
            if (k == 15) begin
                chk("t1_halted_c15", 64'(a_halted), 64'd1);
                chk("t1_reason_c15", 64'(a_halt_reason), 64'd1);
                chk("t1_cycle_c15", a_cycle_cnt, 64'd15);
            end
            if (k == 16) begin
                chk("t1_cycle_frozen", a_cycle_cnt, 64'd15);
                chk("t1_instret", a_instret_cnt, 64'd3);
                chk("t1_req_valid_halt", 64'(a_req_valid), 64'd0);
            end
        end
        chk("t1_pc_wen_cycles", pw_mask, 64'h888);

        // ---------------- ready held low for 5 cycles ----------------
        rom[0] = I_EBRK;
        mem_ready_low = 5; mem_delay = 1;
        do_reset();
        hs = 0;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk); #1;
            if (a_req_valid && imem_req_ready) hs++;
            if (k < 5) begin
                chk("t2_req_valid", 64'(a_req_valid), 64'd1);
                chk("t2_req_addr", a_req_addr, PC0);
            end
        end
        chk("t2_handshakes", 64'(hs), 64'd1);
        chk("t2_halted", 64'(a_halted), 64'd1);
        chk("t2_reason", 64'(a_halt_reason), 64'd1);

        // ---------------- fetch timeout, TIMEOUT=4 ----------------
        rom[0] = I_ADDI1;
        mem_ready_low = 0; mem_delay = 0;
        do_reset();
        gw = 0;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk); #1;
            if (f_gpr_wen || f_pc_wen) gw++;
            if (k == 0) begin
                chk("t3_req_valid", 64'(f_req_valid), 64'd1);
                chk("t3_req_addr", f_req_addr, PC0);
            end
            if (k == 4) chk("t3_not_halted_c4", 64'(f_halted), 64'd0);
            if (k == 5) begin
                chk("t3_halted_c5", 64'(f_halted), 64'd1);
                chk("t3_reason", 64'(f_halt_reason), 64'd3);
                chk("t3_cycle_c5", f_cycle_cnt, 64'd5);
                chk("t3_default_not_halted", 64'(a_halted), 64'd0);
            end
            if (k == 8) chk("t3_cycle_frozen", f_cycle_cnt, 64'd5);
        end
        chk("t3_no_strobes", 64'(gw), 64'd0);
        chk("t3_instret", f_instret_cnt, 64'd0);

        // ---------------- response on the timeout cycle wins ----------------
        rom[0] = I_ADDI1; rom[1] = I_EBRK;
        mem_ready_low = 0; mem_delay = 4;
        do_reset();
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk); #1;
            if (k == 5) begin
                chk("t3b_not_halted", 64'(f_halted), 64'd0);
                chk("t3b_inst", 64'(f_inst), 64'(I_ADDI1));
            end
            if (k == 7) begin
                chk("t3b_instret", f_instret_cnt, 64'd1);
                chk("t3b_still_running", 64'(f_halted), 64'd0);
            end
        end

        // ---------------- illegal instruction with ex_wen=1 ----------------
        rom[0] = I_ILL;
        mem_ready_low = 0; mem_delay = 1; ex_wen = 1'b1;
        do_reset();
        gw = 0; pcw = 0;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk); #1;
            if (a_gpr_wen) gw++;
            if (a_pc_wen) pcw++;
            if (k == 3) begin
                chk("t4_halted_c3", 64'(a_halted), 64'd1);
                chk("t4_reason", 64'(a_halt_reason), 64'd2);
            end
        end
        chk("t4_no_gpr_wen", 64'(gw), 64'd0);
        chk("t4_no_pc_wen", 64'(pcw), 64'd0);
        chk("t4_instret", a_instret_cnt, 64'd0);

        // ---------------- ebreak beats illegal ----------------
        rom[0] = I_EBRK;
        force_ill = 1'b1;
        do_reset();
        repeat (5) begin
            @(negedge clk); #1;
        end
        chk("t4b_halted", 64'(a_halted), 64'd1);
        chk("t4b_reason", 64'(a_halt_reason), 64'd1);
        force_ill = 1'b0;

        // ---------------- reset during WAIT_RSP, late response ----------------
        rom[0] = I_ADDI1; rom[1] = I_EBRK;
        mem_ready_low = 3; mem_delay = 4;
        do_reset();
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk); #1;
            if (k == 3) chk("t5_first_accept", 64'(a_req_valid && imem_req_ready), 64'd1);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk); #1;
            if (k == 0) begin
                chk("t5_refetch_valid", 64'(a_req_valid), 64'd1);
                chk("t5_refetch_addr", a_req_addr, PC0);
            end
            if (k == 2) chk("t5_fetch_during_late_rsp", 64'(a_req_valid), 64'd1);
            if (k == 3) begin
                chk("t5_inst_nop", 64'(a_inst), 64'(I_NOP));
                chk("t5_second_accept", 64'(a_req_valid && imem_req_ready), 64'd1);
                exp_q.delete();
            end
        end
        for (int k = 0; k < 120 && !a_halted; k++) begin
            @(negedge clk); #1;
        end
        chk("t5_halted", 64'(a_halted), 64'd1);
        chk("t5_reason", 64'(a_halt_reason), 64'd1);
        chk("t5_instret", a_instret_cnt, 64'd1);

        // ---------------- TIMEOUT=0, response after 300 cycles ----------------
        rom[0] = I_ADDI1; rom[1] = I_EBRK;
        mem_ready_low = 0; mem_delay = 300;
        do_reset();
        pulses = 0; gw = 0;
        for (int k = 0; k <= 305; k++) begin
            @(negedge clk); #1;
            if (z_pc_wen) pulses++;
            if (z_gpr_wen) gw++;
            if (k == 0) begin
                chk("t6_req_valid", 64'(z_req_valid), 64'd1);
                chk("t6_req_addr", z_req_addr, PC0);
            end
            if (k == 299) chk("t6_not_halted_c299", 64'(z_halted), 64'd0);
        end
        chk("t6_halted", 64'(z_halted), 64'd0);
        chk("t6_reason", 64'(z_halt_reason), 64'd0);
        chk("t6_instret", z_instret_cnt, 64'd1);
        chk("t6_pc_wen_pulses", 64'(pulses), 64'd1);
        chk("t6_gpr_wen_pulses", 64'(gw), 64'd1);
        chk("t6_inst", 64'(z_inst), 64'(I_ADDI1));
        chk("t6_cycle", z_cycle_cnt, 64'd305);
        chk("t6_default_timeout_halt", 64'(a_halted), 64'd1);
        chk("t6_default_timeout_reason", 64'(a_halt_reason), 64'd3);
        chk("t6_default_timeout_cycle", a_cycle_cnt, 64'd256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/npc_seq.md
Name: npc_seq

Overview:
- Multi-cycle control sequencer for the npc RV64 core.
- Fetches each instruction from instruction memory over a valid/ready request and valid response interface, then latches it for idu/exu.
- Gates the GPR write enable and the PC write enable so each instruction commits exactly once.
- Detects ebreak, illegal-instruction and fetch-timeout halts; maintains cycle and instret counters for the simulation harness.

Parameters:
- XLEN, 64, width of PC, fetch address and counters
- TIMEOUT, 255, max WAIT_RSP cycles before timeout halt; 0 disables the timeout
- CNT_W, 8, width of the internal timeout counter

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- pc_val  in  XLEN  current PC from the pc register
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address, equals pc_val while valid
- imem_rsp_valid  in  1  fetch data valid
- imem_rsp_data  in  32  fetched instruction
- inst  out  32  latched instruction to idu
- illegal  in  1  idu flags an undecodable inst
- ex_wen  in  1  exu requests a GPR write
- gpr_wen  out  1  gated GPR write enable
- pc_wen  out  1  PC advance strobe
- halted  out  1  sticky halt flag
- halt_reason  out  2  0 none, 1 ebreak, 2 illegal, 3 timeout
- cycle_cnt  out  XLEN  cycles since reset release, frozen at halt
- instret_cnt  out  XLEN  retired instructions

Behaviour:
- Reset applies on a rising clk edge with rst==0. Reset values:
  - state=FETCH
  - imem_req_valid=0 while rst==0
  - inst=32'h00000013 (nop)
  - gpr_wen=0, pc_wen=0
  - halted=0, halt_reason=0
  - cycle_cnt=0, instret_cnt=0, timeout counter=0
- FETCH:
  - imem_req_valid=1, imem_req_addr=pc_val.
  - Move to WAIT_RSP on the cycle imem_req_valid && imem_req_ready.
  - imem_rsp_valid in FETCH is ignored.
- WAIT_RSP:
  - imem_req_valid=0; the timeout counter increments each cycle.
  - On imem_rsp_valid: inst <= imem_rsp_data, clear the counter, go to DECODE.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT with no response: go to HALT, reason=3.
  - A response in the same cycle the counter reaches TIMEOUT wins; no halt.
- DECODE, one cycle, idu/exu combinational settle:
  - If inst==32'h00100073: go to HALT, reason=1.
  - Else if illegal: go to HALT, reason=2.
  - Otherwise go to EXEC.
  - ebreak takes priority over illegal.
- EXEC, one cycle:
  - gpr_wen=ex_wen, pc_wen=1.
  - instret_cnt+1, then return to FETCH.
  - gpr_wen and pc_wen are 0 in every other state.
- HALT:
  - Terminal; all strobes are 0 and imem_req_valid=0.
  - halted=1, registered on entry.
  - halt_reason and all counters hold.
  - Only reset exits HALT.
  - A halting instruction never writes the GPRs or the PC, and never increments instret.
- Timing:
  - cycle_cnt increments every non-reset cycle while state!=HALT, including the cycle of the transition into HALT.
  - Minimum instruction latency is 4 cycles (ready=1, response one cycle after accept).
- Reset mid-operation:
  - Any outstanding fetch is abandoned.
  - A late imem_rsp_valid after reset release lands in FETCH and is ignored.
- Counters wrap modulo 2^XLEN with no saturation.

Decomposition:
- Shared package npc_pkg holds:
  - state encoding: FETCH, WAIT_RSP, DECODE, EXEC, HALT
  - halt_reason codes
  - INST_EBREAK=32'h00100073
  - INST_NOP=32'h00000013
- One sub-module npc_perf_cnt holds cycle_cnt and instret_cnt, with inputs count_en and retire. The FSM and the timeout counter stay in npc_seq.

Test Plan:
- Reset release; memory always ready, 1-cycle response, three addi followed by ebreak at pc 0x80000000 → EXEC reached at cycles 3, 7, 11; pc_wen pulses three times; instret_cnt=3; halted=1 with reason=1 at cycle 15; cycle_cnt frozen at 15.
- imem_req_ready held low 5 cycles, then high → imem_req_valid and addr stay stable for 5 cycles, and the handshake occurs exactly once.
- Response withheld with TIMEOUT=4 → halt with reason=3 after 4 WAIT_RSP cycles; gpr_wen never asserted.
- Fetched inst with illegal=1 and ex_wen=1 → halt with reason=2; gpr_wen stays 0; instret unchanged.
- rst asserted low during WAIT_RSP, then the response arrives while in FETCH after release → response ignored, inst=nop, and the fetch restarts at pc_val.
- TIMEOUT=0 with the response delayed 300 cycles → no halt; the instruction retires normally with instret_cnt=1.
